// File: rtl/spi_reg_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_reg_master: 16-bit SPI mode-0 register-access master ({rw,addr,data}).  |
// | Optional readback capture enabled by SPI_REG_MASTER_READBACK_EN.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spi_reg_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       copi,
  input  logic       cipo,
  output logic       ncs
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic        half_q, half_d;
  logic [15:0] frame_q, frame_d;
  logic        sclk_q, sclk_d;
  logic        ncs_q, ncs_d;
  logic        copi_q, copi_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic        w_cnt_last;
  logic [3:0]  w_nxt_idx;

  assign w_cnt_last = (cnt_q == c_div_last);
  // Bit presented after the falling edge that ends bit_q's high phase.
  assign w_nxt_idx  = 4'd14 - bit_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    half_d  = half_q;
    frame_d = frame_q;
    sclk_d  = sclk_q;
    ncs_d   = ncs_q;
    copi_d  = copi_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          cnt_d   = 8'd0;
          bit_d   = 4'd0;
          half_d  = 1'b0;
          frame_d = {rw, addr, wdata};
          ncs_d   = 1'b0;
          sclk_d  = 1'b0;
          copi_d  = rw;
        end
      end
      ST_SETUP: begin
        if (w_cnt_last) begin
          state_d = ST_SHIFT;
          cnt_d   = 8'd0;
          sclk_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SHIFT: begin
        if (!w_cnt_last) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = 8'd0;
          if (!half_q) begin
            half_d = 1'b1;
            sclk_d = 1'b0;
            copi_d = (bit_q == 4'd15) ? 1'b0 : frame_q[w_nxt_idx];
          end else if (bit_q == 4'd15) begin
            state_d = ST_HOLD;
            half_d  = 1'b0;
            bit_d   = 4'd0;
          end else begin
            bit_d  = bit_q + 4'd1;
            half_d = 1'b0;
            sclk_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (w_cnt_last) begin
          state_d = ST_GAP;
          cnt_d   = 8'd0;
          ncs_d   = 1'b1;
          copi_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (w_cnt_last) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
        bit_d   = 4'd0;
        half_d  = 1'b0;
        sclk_d  = 1'b0;
        ncs_d   = 1'b1;
        copi_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 4'd0;
      half_q  <= 1'b0;
      frame_q <= 16'h0000;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      copi_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      half_q  <= half_d;
      frame_q <= frame_d;
      sclk_q  <= sclk_d;
      ncs_q   <= ncs_d;
      copi_q  <= copi_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign sclk = sclk_q;
  assign ncs  = ncs_q;
  assign copi = copi_q;
  assign done = done_q;
  assign busy = busy_q;

`ifdef SPI_REG_MASTER_READBACK_EN
  logic [7:0] rx_q, rx_d;
  logic [7:0] rdata_q, rdata_d;
  logic       w_rx_sample;
  logic       w_frame_end;

  // Data-byte rising edges (9..16) of a read frame, in the cycle sclk goes high.
  assign w_rx_sample = (state_q == ST_SHIFT) && !half_q && (cnt_q == 8'd0) &&
                       bit_q[3] && !frame_q[15];
  assign w_frame_end = (state_q == ST_HOLD) && w_cnt_last;

  always_comb begin
    rx_d    = rx_q;
    rdata_d = rdata_q;
    if (w_rx_sample) begin
      rx_d = {rx_q[6:0], cipo};
    end
    if (w_frame_end && !frame_q[15]) begin
      rdata_d = rx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q    <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
`else
  logic w_unused_cipo;
  assign w_unused_cipo = cipo;
  assign rdata         = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_reg_master: directed frames with a negedge bus monitor.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_spi_reg_master;

  localparam int D = 4;
`ifdef SPI_REG_MASTER_READBACK_EN
  localparam logic [7:0] c_exp_rdata = 8'hA5;
  localparam logic [7:0] c_rd_byte   = 8'hA5;
  localparam logic       c_rd_idle   = 1'b0;
`else
  localparam logic [7:0] c_exp_rdata = 8'h00;
  localparam logic [7:0] c_rd_byte   = 8'hFF;
  localparam logic       c_rd_idle   = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst, start, rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy, done;
  logic [7:0] rdata;
  logic       sclk, copi, cipo, ncs;

  always #5 clk = ~clk;

  spi_reg_master #(.CLK_DIV(D)) u_dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .sclk(sclk), .copi(copi),
    .cipo(cipo), .ncs(ncs)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Bus monitor state; only the monitor writes these, clears are requested via clr_seq.
  int          clr_seq = 0;
  int          clr_seen = 0;
  int          m_rises, m_ncs_low, m_busy, m_done, m_viol, m_hi_run, m_gaps;
  int          m_gap [2];
  logic [15:0] m_frame;
  logic [7:0]  m_done_rdata;
  bit          m_seen_low;
  logic        p_sclk, p_ncs, p_copi;
  bit          chk_en = 1'b0;
  logic [7:0]  cipo_byte = 8'h00;
  logic        cipo_idle = 1'b0;

  always @(negedge clk) begin
    if (clr_seen != clr_seq) begin
      clr_seen = clr_seq;
      m_rises = 0; m_ncs_low = 0; m_busy = 0; m_done = 0; m_viol = 0;
      m_hi_run = 0; m_gaps = 0; m_gap[0] = 0; m_gap[1] = 0;
      m_frame = 16'h0000; m_done_rdata = 8'h00; m_seen_low = 1'b0;
    end
    if (sclk === 1'b1 && p_sclk === 1'b0) begin
      m_rises++;
      m_frame = {m_frame[14:0], copi};
    end
    if (ncs === 1'b0) m_ncs_low++;
    if (busy === 1'b1) m_busy++;
    if (done === 1'b1) begin
      m_done++;
      m_done_rdata = rdata;
    end
    if (chk_en) begin
      if (ncs === 1'b1 && copi !== 1'b0) m_viol++;
      if (copi !== p_copi && !(p_sclk === 1'b1 && sclk === 1'b0) && ncs === p_ncs) m_viol++;
      if (ncs !== p_ncs && (sclk !== 1'b0 || p_sclk !== 1'b0)) m_viol++;
    end
    if (ncs === 1'b1) begin
      m_hi_run++;
    end else begin
      if (p_ncs === 1'b1 && m_seen_low && m_gaps < 2) begin
        m_gap[m_gaps] = m_hi_run;
        m_gaps++;
      end
      m_hi_run   = 0;
      m_seen_low = 1'b1;
    end
    // Slave model: change cipo only while sclk is low, ahead of the next rise.
    if (sclk === 1'b0)
      cipo = (m_rises >= 8 && m_rises <= 15) ? cipo_byte[15 - m_rises] : cipo_idle;
    p_sclk = sclk;
    p_ncs  = ncs;
    p_copi = copi;
  end

  task automatic run_frame(input logic f_rw, input logic [6:0] f_addr,
                           input logic [7:0] f_wdata, input bit poke);
    clr_seq++;
    @(negedge clk);
    rw = f_rw; addr = f_addr; wdata = f_wdata; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400 && busy === 1'b1; i++) begin
      @(negedge clk);
      if (poke && i == 50) begin
        start = 1'b1; rw = 1'b0; addr = 7'h7F; wdata = 8'h00;
      end
      if (poke && i == 51) start = 1'b0;
    end
    if (busy !== 1'b0) check("frame_timeout", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; rw = 1'b0; addr = 7'h00; wdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ncs",   32'(ncs),   32'd1);
    check("rst_sclk",  32'(sclk),  32'd0);
    check("rst_copi",  32'(copi),  32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_rdata", 32'(rdata), 32'h00);
    rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;

    // Write 0x00 <- 0xFF
    run_frame(1'b1, 7'h00, 8'hFF, 1'b0);
    check("w1_frame",   32'(m_frame), 32'h80FF);
    check("w1_rises",   m_rises,      32'd16);
    check("w1_ncs_low", m_ncs_low,    32'd136);
    check("w1_done",    m_done,       32'd1);
    check("w1_viol",    m_viol,       32'd0);

    // Read 0x02 with slave byte on cipo
    cipo_byte = c_rd_byte;
    cipo_idle = c_rd_idle;
    run_frame(1'b0, 7'h02, 8'h00, 1'b0);
    check("rd_frame",      32'(m_frame),      32'h0200);
    check("rd_done",       m_done,            32'd1);
    check("rd_done_rdata", 32'(m_done_rdata), 32'(c_exp_rdata));
    check("rd_viol",       m_viol,            32'd0);
    cipo_byte = 8'h00;
    cipo_idle = 1'b0;

    // Write 0x04 <- 0x80 with a start pulse and input churn mid-frame
    run_frame(1'b1, 7'h04, 8'h80, 1'b1);
    check("w2_frame",   32'(m_frame), 32'h8480);
    check("w2_rises",   m_rises,      32'd16);
    check("w2_busy",    m_busy,       32'd140);
    check("w2_done",    m_done,       32'd1);
    check("w2_rdata",   32'(rdata),   32'(c_exp_rdata));
    repeat (3) @(negedge clk);
    check("w2_no_queue", 32'(busy),   32'd0);

    // Reset on the 5th sclk rise
    chk_en = 1'b0;
    clr_seq++;
    @(negedge clk);
    rw = 1'b1; addr = 7'h11; wdata = 8'h22; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    for (int i = 0; i < 300 && m_rises < 5; i++) begin
      @(negedge clk);
      #1;
    end
    check("ra_rises", m_rises, 32'd5);
    rst = 1'b1;
    @(negedge clk);
    check("ra_ncs",  32'(ncs),  32'd1);
    check("ra_sclk", 32'(sclk), 32'd0);
    check("ra_copi", 32'(copi), 32'd0);
    check("ra_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("ra_no_done", m_done,     32'd0);
    check("ra_rdata",   32'(rdata), 32'h00);

    // Reset has priority over start
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check("rs_busy", 32'(busy), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rs_idle", 32'(busy), 32'd0);
    chk_en = 1'b1;

    run_frame(1'b1, 7'h01, 8'h55, 1'b0);
    check("w3_frame",   32'(m_frame), 32'h8155);
    check("w3_ncs_low", m_ncs_low,    32'd136);
    check("w3_done",    m_done,       32'd1);
    check("w3_viol",    m_viol,       32'd0);

    // Back-to-back frames with start held high
    clr_seq++;
    @(negedge clk);
    rw = 1'b1; addr = 7'h03; wdata = 8'h3C; start = 1'b1;
    #1;
    for (int i = 0; i < 2000 && m_gaps < 2; i++) begin
      @(negedge clk);
      #1;
    end
    start = 1'b0;
    for (int i = 0; i < 400 && busy === 1'b1; i++) @(negedge clk);
    #1;
    check("bb_gaps", m_gaps,   32'd2);
    check("bb_gap0", m_gap[0], 32'(D + 1));
    check("bb_gap1", m_gap[1], 32'(D + 1));
    check("bb_viol", m_viol,   32'd0);
    check("bb_frame", 32'(m_frame), 32'h833C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
